// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the binary64 normalize/round datapath.
//   * rounding-mode encodings (rm_e)
//   * exponent bias and the all-ones (inf/NaN) exponent code
//   * bit positions of the {overflow, underflow, inexact, zero} flag vector
//   * S1 -> S2 pipeline register layout (s1_t)
//   * round_inc(): round-up decision from lsb/guard/sticky/sign
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,  // nearest, ties to even
        RM_RTZ = 2'd1,  // toward zero
        RM_RUP = 2'd2,  // toward +inf
        RM_RDN = 2'd3   // toward -inf
    } rm_e;

    localparam int unsigned EXP_BIAS = 1023;
    localparam int unsigned EXP_MAX  = 2047;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    // Normalized operand as it leaves the shifter: mant has its leading
    // one at bit 63 unless the operand was zero.
    typedef struct packed {
        logic               sign;
        logic signed [12:0] exp;
        logic [63:0]        mant;
        logic               sticky;
        rm_e                rm;
        logic               zero;
    } s1_t;

    function automatic logic round_inc(input rm_e rm, input logic sign,
                                       input logic lsb, input logic guard,
                                       input logic sticky);
        logic inc;
        case (rm)
            RM_RNE:  inc = guard & (sticky | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = (guard | sticky) & ~sign;
            default: inc = (guard | sticky) & sign;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/lzc_64_hierarchical.sv
// lzc_64_hierarchical -- 64-bit leading-zero counter.
//   data_i  [63:0] : word to scan
//   count_o [6:0]  : number of leading zeros, 0..64 (64 when data_i == 0)
// Counts within each byte first, then picks the most significant non-zero
// byte, so the long priority chain is only eight entries deep.
module lzc_64_hierarchical (
    input  logic [63:0] data_i,
    output logic [6:0]  count_o
);

    function automatic logic [2:0] lz8(input logic [7:0] v);
        logic [2:0] n;
        n = 3'd7;
        for (int i = 0; i < 8; i++)
            if (v[i]) n = 3'(7 - i);
        return n;
    endfunction

    // Index 0 is the most significant byte.
    logic [7:0][2:0] byte_lz;
    logic [7:0]      byte_nz;

    for (genvar b = 0; b < 8; b++) begin : g_byte
        always_comb begin
            byte_nz[b] = |data_i[63-8*b -: 8];
            byte_lz[b] = lz8(data_i[63-8*b -: 8]);
        end
    end

    always_comb begin
        count_o = 7'd64;
        for (int b = 7; b >= 0; b--)
            if (byte_nz[b]) count_o = 7'(8 * b) + {4'd0, byte_lz[b]};
    end

endmodule

// File: rtl/fp_normalize_round.sv
// fp_normalize_round -- two-stage normalize / round / pack to IEEE-754 binary64.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   in_sign               : result sign
//   in_exp  [12:0] signed : biased exponent (bias 1023)
//   in_mant [63:0]        : magnitude, value = in_mant/2^62 * 2^(in_exp-1023)
//   in_sticky             : OR of bits discarded upstream
//   in_rm   [1:0]         : rounding mode (rm_e)
//   out_valid / out_ready : downstream handshake
//   out_result [63:0]     : packed binary64
//   out_flags  [3:0]      : {overflow, underflow, inexact, zero}
// S1: leading-zero count and left shift. S2: round, exponent adjust, pack.
// Optional macro FPNR_SUBNORMAL_EN: tiny results are denormalized and
// rounded; without it they flush to signed zero.
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic signed [12:0] in_exp,
    input  logic [63:0]        in_mant,
    input  logic               in_sticky,
    input  logic [1:0]         in_rm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_result,
    output logic [3:0]         out_flags
);

    localparam logic signed [13:0] E_OVF     = 14'(EXP_MAX);
    localparam logic [10:0]        EXP_INF   = 11'(EXP_MAX);
    localparam logic [10:0]        EXP_MAXFN = 11'(2 * EXP_BIAS);

    // ---------------------------------------------------------------- S1
    logic [6:0] lz;
    s1_t        s1_d, s1_q;
    logic       s1_valid_q;
    logic       s1_advance;

    lzc_64_hierarchical u_lzc (
        .data_i  (in_mant),
        .count_o (lz)
    );

    always_comb begin
        s1_d        = '0;
        s1_d.sign   = in_sign;
        s1_d.exp    = in_exp + 13'sd1 - $signed({6'd0, lz});
        s1_d.mant   = in_mant << lz;
        s1_d.sticky = in_sticky;
        s1_d.rm     = rm_e'(in_rm);
        s1_d.zero   = (in_mant == 64'd0);
    end

    assign s1_advance = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid_q | s1_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // ---------------------------------------------------------------- S2
    logic signed [13:0] e_pre, e_post;
    logic               tiny;
    logic [63:0]        sig_r;
    logic               lost;
    logic [52:0]        m;
    logic               g, st, inexact, inc;
    logic               carry, hid;
    logic [51:0]        frac;
    logic [10:0]        exp_f;
    logic               ovf, to_inf;
    logic [63:0]        res_d;
    logic [3:0]         flags_d;
`ifdef FPNR_SUBNORMAL_EN
    logic signed [13:0] sh_full;
    logic [6:0]         sh;
`endif

    always_comb begin
        e_pre = {s1_q.exp[12], s1_q.exp};
        tiny  = (e_pre <= 14'sd0);
        sig_r = s1_q.mant;
        lost  = 1'b0;
`ifdef FPNR_SUBNORMAL_EN
        sh_full = 14'sd1 - e_pre;
        sh      = 7'd0;
        if (tiny) begin
            // Denormalize by 1-e; beyond 64 everything lands in sticky.
            sh    = (e_pre <= -14'sd63) ? 7'd64 : sh_full[6:0];
            sig_r = s1_q.mant >> sh;
            lost  = |(s1_q.mant & ~({64{1'b1}} << sh));
        end
`endif
        m       = sig_r[63:11];
        g       = sig_r[10];
        st      = (|sig_r[9:0]) | s1_q.sticky | lost;
        inexact = g | st;
        inc     = round_inc(s1_q.rm, s1_q.sign, m[0], g, st);
        // carry: significand rolled over to 2.0; hid: hidden bit of the
        // rounded result (for a denormal, it marks rounding into min normal).
        {carry, hid, frac} = {1'b0, m} + {53'd0, inc};
        e_post  = e_pre + $signed({13'd0, carry});
        exp_f   = tiny ? {10'd0, hid} : e_post[10:0];
        ovf     = ~tiny & (e_post >= E_OVF);
        to_inf  = (s1_q.rm == RM_RNE) | ((s1_q.rm == RM_RUP) & ~s1_q.sign)
                | ((s1_q.rm == RM_RDN) & s1_q.sign);

        res_d   = '0;
        flags_d = '0;
        if (s1_q.zero) begin
            res_d              = {s1_q.sign, 63'd0};
            flags_d[FLAG_ZERO] = 1'b1;
        end else if (tiny) begin
`ifdef FPNR_SUBNORMAL_EN
            res_d              = {s1_q.sign, exp_f, frac};
            flags_d[FLAG_UNF]  = inexact;
            flags_d[FLAG_INX]  = inexact;
            flags_d[FLAG_ZERO] = ({exp_f, frac} == 63'd0);
`else
            res_d              = {s1_q.sign, 63'd0};
            flags_d[FLAG_UNF]  = 1'b1;
            flags_d[FLAG_INX]  = 1'b1;
            flags_d[FLAG_ZERO] = 1'b1;
`endif
        end else if (ovf) begin
            res_d = to_inf ? {s1_q.sign, EXP_INF, 52'd0}
                           : {s1_q.sign, EXP_MAXFN, {52{1'b1}}};
            flags_d[FLAG_OVF] = 1'b1;
            flags_d[FLAG_INX] = 1'b1;
        end else begin
            res_d             = {s1_q.sign, exp_f, frac};
            flags_d[FLAG_INX] = inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_result <= res_d;
                out_flags  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round -- directed scoreboard bench for fp_normalize_round.
// Stimulus changes on the falling edge; outputs are sampled shortly after it.
module tb_fp_normalize_round;

    logic               clk, rst_n;
    logic               in_valid, in_ready;
    logic               in_sign;
    logic signed [12:0] in_exp;
    logic [63:0]        in_mant;
    logic               in_sticky;
    logic [1:0]         in_rm;
    logic               out_valid, out_ready;
    logic [63:0]        out_result;
    logic [3:0]         out_flags;

    fp_normalize_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3;

    typedef struct packed {
        logic [63:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Present one operand and hold it until accepted; returns on the falling
    // edge after the accepting rising edge with in_valid still high.
    task automatic send(input logic s, input logic [12:0] e, input logic [63:0] mt,
                        input logic stk, input logic [1:0] rm,
                        input logic [63:0] xr, input logic [3:0] xf);
        int n;
        in_sign = s; in_exp = e; in_mant = mt; in_sticky = stk; in_rm = rm;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("accept", {63'd0, in_ready}, 64'd1);
        sb.push_back(exp_t'{xr, xf});
        @(negedge clk);
    endtask

    // Output monitor / scoreboard.
    always begin
        @(negedge clk); #2;
        if (rst_n && out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: observed %h expected no output", out_result);
            end
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("result", out_result, x.r);
                chk("flags", {60'd0, out_flags}, {60'd0, x.f});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; in_rm = RNE;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", {60'd0, out_flags}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: visible two edges after being presented.
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0000, 1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0000);
        in_valid = 1'b0;
        #1 chk("lat_1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        #1 chk("lat_2", {63'd0, out_valid}, 64'd1);
        @(negedge clk);

        // Directed values, back-to-back at full throughput.
        send(1'b0, 13'd1085, 64'h1,                   1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0000);
        send(1'b0, 13'd1023, 64'h7FFF_FFFF_FFFF_FE00, 1'b0, RNE, 64'h4000_0000_0000_0000, 4'b0010);
        send(1'b0, 13'd2046, 64'h8000_0000_0000_0000, 1'b0, RNE, 64'h7FF0_0000_0000_0000, 4'b1010);
        send(1'b0, 13'd2046, 64'h8000_0000_0000_0000, 1'b0, RTZ, 64'h7FEF_FFFF_FFFF_FFFF, 4'b1010);
        send(1'b1, 13'd2046, 64'h8000_0000_0000_0000, 1'b0, RDN, 64'hFFF0_0000_0000_0000, 4'b1010);
        send(1'b1, 13'd2046, 64'h8000_0000_0000_0000, 1'b0, RUP, 64'hFFEF_FFFF_FFFF_FFFF, 4'b1010);
        send(1'b0, 13'd2046, 64'h7FFF_FFFF_FFFF_FE00, 1'b0, RNE, 64'h7FF0_0000_0000_0000, 4'b1010);
        send(1'b1, 13'd500,  64'h0,                   1'b1, RNE, 64'h8000_0000_0000_0000, 4'b0001);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0001, 1'b0, RUP, 64'h3FF0_0000_0000_0001, 4'b0010);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0001, 1'b0, RDN, 64'h3FF0_0000_0000_0000, 4'b0010);
        send(1'b1, 13'd1023, 64'h4000_0000_0000_0001, 1'b0, RDN, 64'hBFF0_0000_0000_0001, 4'b0010);
        send(1'b1, 13'd1023, 64'h4000_0000_0000_0001, 1'b0, RTZ, 64'hBFF0_0000_0000_0000, 4'b0010);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0200, 1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0010);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0200, 1'b1, RNE, 64'h3FF0_0000_0000_0001, 4'b0010);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0600, 1'b0, RNE, 64'h3FF0_0000_0000_0002, 4'b0010);
        send(1'b0, 13'd1,    64'h4000_0000_0000_0000, 1'b0, RNE, 64'h0010_0000_0000_0000, 4'b0000);
`ifdef FPNR_SUBNORMAL_EN
        send(1'b0, 13'd0,    64'h4000_0000_0000_0000, 1'b0, RNE, 64'h0008_0000_0000_0000, 4'b0000);
`else
        send(1'b0, 13'd0,    64'h4000_0000_0000_0000, 1'b0, RNE, 64'h0000_0000_0000_0000, 4'b0111);
`endif
        in_valid = 1'b0;

        // Back-pressure: two accepts fill the pipe, the third waits.
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0000, 1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0000);
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0200, 1'b1, RNE, 64'h3FF0_0000_0000_0001, 4'b0010);
        in_mant = 64'h4000_0000_0000_0600; in_sticky = 1'b0; in_exp = 13'd1023;
        sb.push_back(exp_t'{64'h3FF0_0000_0000_0002, 4'b0010});
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", out_result, 64'h3FF0_0000_0000_0000);
            chk("stall_flags", {60'd0, out_flags}, 64'd0);
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);

        // Reset with two operands in flight.
        out_ready = 1'b0;
        send(1'b0, 13'd1023, 64'h4000_0000_0000_0000, 1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0000);
        send(1'b0, 13'd1085, 64'h1,                   1'b0, RNE, 64'h3FF0_0000_0000_0000, 4'b0000);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_result", out_result, 64'd0);
        chk("arst_flags", {60'd0, out_flags}, 64'd0);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end
        @(negedge clk);

        // Pipeline still usable after reset.
        send(1'b1, 13'd1023, 64'h7FFF_FFFF_FFFF_FE00, 1'b0, RNE, 64'hC000_0000_0000_0000, 4'b0010);
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
